counter_apb_arbiter: RTL
========================

// Module: counter_apb_arbiter
// PURPOSE
//  Two-requester APB master that shares the APB counter register block between
//  requester 0 and requester 1. Each requester uses a valid/ready command port.
//  Commands are arbitrated round-robin and sequenced through APB SETUP/ACCESS.
//  Read data or an error comes back on a per-requester response pulse.
//  Sits between local control logic (e.g. reset scheduler, sampler) and the
//  counter APB slave (0x00 ID, 0x04 counter reset, 0x08 counter value).
// PARAMETERS
//  TIMEOUT  16  max ACCESS cycles waiting for PREADY before abort; 0 = never abort
// PORTS
//  PCLK          in   1   clock
//  PRESETn       in   1   async active-low reset
//  req0_valid    in   1   requester 0 command valid
//  req0_ready    out  1   requester 0 command accepted (valid&&ready)
//  req0_write    in   1   1=write, 0=read
//  req0_addr     in   32  APB address
//  req0_wdata    in   32  write data
//  rsp0_valid    out  1   one-cycle response pulse to requester 0
//  rsp0_err      out  1   timeout abort flag, valid with rsp0_valid
//  rsp0_rdata    out  32  read data (0 for writes/errors), valid with rsp0_valid
//  req1_*/rsp1_* same set as above, for requester 1
//  PADDR         out  32  APB address
//  PSEL          out  1   APB select
//  PENABLE       out  1   APB enable
//  PWRITE        out  1   APB direction
//  PWDATA        out  32  APB write data
//  PRDATA        in   32  APB read data
//  PREADY        in   1   APB ready (may be held low for wait states)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last_grant=1 (req0 wins first tie), wait count 0.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//  - IDLE: reqN_ready = (state==IDLE) && grant==N, combinational from valids.
//    Exactly one ready per cycle at most.
//    Grant if one valid: that requester. If both valid: the one != last_grant.
//  - On acceptance, latch addr/wdata/write/owner. Update last_grant. Go to SETUP.
//  - SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable. Go to ACCESS.
//  - ACCESS: PSEL=1, PENABLE=1, all APB outputs held stable until exit.
//    Exit with PREADY=1: capture PRDATA for reads, 0 for writes.
//    Next cycle: rspN_valid=1, err=0, APB outputs to 0, state IDLE.
//  - Timeout: wait count increments each ACCESS cycle with PREADY=0.
//    If TIMEOUT!=0 and count reaches TIMEOUT, leave ACCESS.
//    Next cycle: rspN_valid=1, err=1, rdata=0.
//  - Latency with zero-wait slave: accept at T, SETUP T+1, ACCESS T+2, rsp at T+3.
//    IDLE at T+3 may accept the next command; max throughput is 1 per 3 cycles.
//  - rsp pulses last exactly 1 cycle. rdata/err hold their value until the next
//    response to that requester.
//  - Valid dropped before ready: nothing issued (no commitment before acceptance).
//  - Reset asserted mid-transfer: PSEL/PENABLE drop asynchronously.
//    The transfer is lost and no response is issued.
// TESTING
//  - Read 0x00 from req0, PREADY=1: rsp0_valid at T+3, rsp0_rdata=0x000DECAF, err=0.
//  - Both valid from reset: req0 served first, then req1; next tie serves req1 first.
//  - req1 writes 0x04 data 1, then reads 0x08: PWRITE=1 at SETUP; read returns 0x0.
//  - PREADY low 3 ACCESS cycles: PENABLE held 4 cycles, APB lines stable, rsp at T+6.
//  - PREADY stuck low, TIMEOUT=16: abort after 16 ACCESS cycles; err=1, rdata=0.
//  - PRESETn low during ACCESS: PSEL=PENABLE=0 at once, no rsp pulse, req0 wins next tie.

Source files
------------

// File: rtl/counter_apb_arbiter_if.sv
// Requester command/response port and APB bus bundles used by counter_apb_arbiter.
// Modports: master drives the request side, slave answers it.

interface counter_apb_req_if;
    logic        valid;
    logic        ready;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (output valid, write, addr, wdata,
                    input  ready, rsp_valid, rsp_err, rsp_rdata);
    modport slave  (input  valid, write, addr, wdata,
                    output ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

interface counter_apb_bus_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport master (output paddr, psel, penable, pwrite, pwdata,
                    input  prdata, pready);
    modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                    output prdata, pready);
endinterface

// File: rtl/counter_apb_arbiter.sv
// Round-robin APB master sharing the counter register block between two requesters.
// state  | meaning
// IDLE   | APB idle, one requester may be accepted this cycle
// SETUP  | PSEL=1, PENABLE=0 for the latched command
// ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout

module counter_apb_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    counter_apb_req_if.slave  req0,
    counter_apb_req_if.slave  req1,
    counter_apb_bus_if.master apb
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TC = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            r_owner;
    logic            r_write;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [CW-1:0]   r_wait_cnt;
    logic [1:0]      r_rsp_valid;
    logic [1:0]      r_rsp_err;
    logic [1:0][31:0] r_rsp_rdata;

    logic w_any_valid;
    logic w_grant;
    logic w_accept;
    logic w_done;
    logic w_tmo;
    logic w_exit;

    // On a tie the requester that did not win last time is chosen.
    assign w_any_valid = req0.valid | req1.valid;
    assign w_grant     = (req0.valid & req1.valid) ? ~r_last_grant : req1.valid;
    assign w_accept    = (r_state == S_IDLE) & w_any_valid;
    assign w_done      = (r_state == S_ACCESS) & apb.pready;
    assign w_tmo       = (TIMEOUT != 0) && (r_state == S_ACCESS) && !apb.pready &&
                         (r_wait_cnt == CW'(TC));
    assign w_exit      = w_done | w_tmo;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_exit) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req0.ready  = 1'b0;
        req1.ready  = 1'b0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.paddr   = '0;
        apb.pwrite  = 1'b0;
        apb.pwdata  = '0;
        case (r_state)
            S_IDLE: begin
                req0.ready = req0.valid & ~w_grant;
                req1.ready = req1.valid &  w_grant;
            end
            S_SETUP: begin
                apb.psel   = 1'b1;
                apb.paddr  = r_addr;
                apb.pwrite = r_write;
                apb.pwdata = r_wdata;
            end
            S_ACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = 1'b1;
                apb.paddr   = r_addr;
                apb.pwrite  = r_write;
                apb.pwdata  = r_wdata;
            end
            default: ;
        endcase
        req0.rsp_valid = r_rsp_valid[0];
        req0.rsp_err   = r_rsp_err[0];
        req0.rsp_rdata = r_rsp_rdata[0];
        req1.rsp_valid = r_rsp_valid[1];
        req1.rsp_err   = r_rsp_err[1];
        req1.rsp_rdata = r_rsp_rdata[1];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait_cnt   <= '0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_write      <= w_grant ? req1.write : req0.write;
                r_addr       <= w_grant ? req1.addr  : req0.addr;
                r_wdata      <= w_grant ? req1.wdata : req0.wdata;
            end

            if (r_state == S_ACCESS) begin
                if (!apb.pready) r_wait_cnt <= w_tmo ? '0 : r_wait_cnt + CW'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            // Pulses clear every cycle; err/rdata keep their last response value.
            r_rsp_valid <= '0;
            if (w_exit) begin
                r_rsp_valid[r_owner] <= 1'b1;
                r_rsp_err[r_owner]   <= w_tmo;
                r_rsp_rdata[r_owner] <= (w_done & ~r_write) ? apb.prdata : 32'h0;
            end
        end
    end

endmodule
